aes256_encrypt_core: RTL

- Iterative AES-256 forward cipher (FIPS-197): one 128-bit block per transaction, one round per clock, round keys expanded on the fly from the 256-bit key.
- It is the encrypt-direction counterpart of the decryption datapath.
- In CTR mode it is the keystream generator: the counter block goes in, and its output is XORed with data outside this block.
- Valid/ready handshake on input and output.

---
 rtl/aes256_encrypt_core.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encryption core: one round per clock, round keys derived
// on the fly from the previous two key blocks, valid/ready on both sides.

module sbox8 (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] xtime8(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime8(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0.
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign inv  = gf_mul(gf_mul(x240, x12), x2);

  assign s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes256_encrypt_core #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [255:0] key_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] kprev_q, kprev_d;
  logic [127:0] kcur_q, kcur_d;
  logic [127:0] ct_q, ct_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] xtime8(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   sub_b [16];
  logic [7:0]   sr_b  [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;
  logic [127:0] round_out;

  genvar gi;
  // Byte gi sits at row gi%4, column gi/4; ShiftRows pulls from column (c+r)%4.
  for (gi = 0; gi < 16; gi++) begin : g_bytes
    sbox8 u_sbox (.a(blk_q[127-8*gi -: 8]), .s(sub_b[gi]));
    assign sr_b[gi] = sub_b[(((gi / 4) + (gi % 4)) % 4) * 4 + (gi % 4)];
    assign sr_flat[127-8*gi -: 8] = sr_b[gi];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_b[4*gi];
    assign a1 = sr_b[4*gi+1];
    assign a2 = sr_b[4*gi+2];
    assign a3 = sr_b[4*gi+3];
    assign mc_flat[127-32*gi -: 32] = {
      xtime8(a0) ^ xtime8(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime8(a1) ^ xtime8(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime8(a2) ^ xtime8(a3) ^ a3,
      xtime8(a0) ^ a0 ^ a1 ^ a2 ^ xtime8(a3)};
  end

  assign round_out = ((round_q == LAST_ROUND) ? sr_flat : mc_flat) ^ kcur_q;

  // Next key block: j = r+1 selects RotWord+Rcon (even) or plain SubWord (odd).
  logic [3:0]   key_j;
  logic         key_j_even;
  logic [31:0]  t_in, t_sub, t_word;
  logic [7:0]   rcon;
  logic [31:0]  nk0, nk1, nk2, nk3;

  assign key_j      = round_q + 4'd1;
  assign key_j_even = ~key_j[0];
  assign t_in       = key_j_even ? {kcur_q[23:0], kcur_q[31:24]} : kcur_q[31:0];

  for (gi = 0; gi < 4; gi++) begin : g_key_sbox
    sbox8 u_ksbox (.a(t_in[8*gi +: 8]), .s(t_sub[8*gi +: 8]));
  end

  assign rcon   = 8'h01 << (key_j[3:1] - 3'd1);
  assign t_word = t_sub ^ (key_j_even ? {rcon, 24'h000000} : 32'h0);
  assign nk0    = kprev_q[127:96] ^ t_word;
  assign nk1    = kprev_q[95:64]  ^ nk0;
  assign nk2    = kprev_q[63:32]  ^ nk1;
  assign nk3    = kprev_q[31:0]   ^ nk2;

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    blk_d       = blk_q;
    kprev_d     = kprev_q;
    kcur_d      = kcur_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext ^ key_i[255:128];
          kprev_d = key_i[255:128];
          kcur_d  = key_i[127:0];
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        blk_d   = round_out;
        kprev_d = kcur_q;
        kcur_d  = {nk0, nk1, nk2, nk3};
        round_d = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          ct_d        = round_out;
          out_valid_d = 1'b1;
          round_d     = 4'd0;
          fsm_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      blk_q       <= '0;
      kprev_q     <= '0;
      kcur_q      <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      blk_q       <= blk_d;
      kprev_q     <= kprev_d;
      kcur_q      <= kcur_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = rst && (fsm_q == IDLE);
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
  assign busy       = (fsm_q != IDLE);
endmodule
